// File: rtl/hs32_fetch_pkg.sv
// Shared types for the hs32 front end: instruction word, fetch-queue entry
// and the word-alignment helper used on redirect targets.
package hs32_fetch_pkg;

   localparam int HS32_INSTR_BYTES = 4;

   typedef logic [31:0] hs32_instr;

   typedef struct packed {
      logic [31:0] pc;
      hs32_instr   instr;
   } hs32_fetch_ent;

   function automatic logic [31:0] hs32_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/hs32_fifo.sv
// Generic synchronous FIFO with flush; DEPTH must be a power of two so the
// read/write pointers wrap on their own.
module hs32_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             data_i,
   input  logic                         pop_i,
   input  logic                         flush_i,
   output logic [WIDTH-1:0]             data_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         empty_o,
   output logic                         full_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr, r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_pop, w_push;

   assign empty_o = (r_count == '0);
   assign full_o  = (r_count == CW'(DEPTH));
   assign count_o = r_count;
   assign data_o  = r_mem[r_rptr];

   // A push into a full FIFO is only taken when a pop frees the slot.
   assign w_pop  = pop_i & ~empty_o;
   assign w_push = push_i & (~full_o | w_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push && !flush_i) r_mem[r_wptr] <= data_i;
   end

endmodule

// File: rtl/hs32_fetch.sv
// hs32 instruction fetch: credit-limited sequential fetch into a prefetch
// FIFO with flush/discard handling. HS32_FETCH_BYPASS_EN enables FIFO bypass.
module hs32_fetch
   import hs32_fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_gnt_i,
   input  logic        ibus_rvalid_i,
   input  logic [31:0] ibus_rdata_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] data_o,
   output logic [31:0] pc_o
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int DW = CW + 1;

   logic [31:0]   r_pc, r_rsp_pc;
   logic [CW-1:0] r_outstanding;
   logic [DW-1:0] r_discard;

   logic [CW-1:0] w_fifo_count;
   logic          w_fifo_empty, w_fifo_full;
   hs32_fetch_ent w_head, w_wr_ent;
   logic [CW:0]   w_inflight;
   logic [DW:0]   w_flush_pend;
   logic          w_req, w_gnt, w_drop, w_rsp_take, w_byp, w_push;

   assign w_inflight = (CW+1)'(r_outstanding) + (CW+1)'(w_fifo_count);
   assign w_req      = rst_ni & ~flush_i & ~w_fifo_full & (w_inflight < (CW+1)'(DEPTH));
   assign w_gnt      = w_req & ibus_gnt_i;
   assign w_drop     = (r_discard != '0);
   assign w_rsp_take = ibus_rvalid_i & ~w_drop;

   // Everything still on the bus after a flush must be dropped, minus a
   // response arriving in the flush cycle itself.
   assign w_flush_pend = (DW+1)'(r_discard) + (DW+1)'(r_outstanding)
                       - (DW+1)'(ibus_rvalid_i & (w_drop | (r_outstanding != '0)));

`ifdef HS32_FETCH_BYPASS_EN
   assign w_byp = w_fifo_empty & w_rsp_take & ~flush_i;
`else
   assign w_byp = 1'b0;
`endif

   assign w_push   = w_rsp_take & ~flush_i & ~(w_byp & ready_i);
   assign w_wr_ent = '{pc: r_rsp_pc, instr: ibus_rdata_i};

   hs32_fifo #(
      .WIDTH ($bits(hs32_fetch_ent)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_push),
      .data_i  (w_wr_ent),
      .pop_i   (ready_i),
      .flush_i (flush_i),
      .data_o  (w_head),
      .count_o (w_fifo_count),
      .empty_o (w_fifo_empty),
      .full_o  (w_fifo_full)
   );

   assign ibus_req_o  = w_req;
   assign ibus_addr_o = r_pc;
   assign valid_o     = ~w_fifo_empty | w_byp;
   assign data_o      = ~w_fifo_empty ? w_head.instr : (w_byp ? ibus_rdata_i : 32'h0);
   assign pc_o        = ~w_fifo_empty ? w_head.pc    : (w_byp ? r_rsp_pc     : 32'h0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pc          <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else if (flush_i) begin
         r_pc          <= hs32_align(flush_pc_i);
         r_rsp_pc      <= hs32_align(flush_pc_i);
         r_outstanding <= '0;
         r_discard     <= w_flush_pend[DW] ? '1 : w_flush_pend[DW-1:0];
      end else begin
         if (w_gnt)                   r_pc      <= r_pc + 32'(HS32_INSTR_BYTES);
         if (w_rsp_take)              r_rsp_pc  <= r_rsp_pc + 32'(HS32_INSTR_BYTES);
         if (ibus_rvalid_i && w_drop) r_discard <= r_discard - DW'(1);
         case ({w_gnt, w_rsp_take})
            2'b10:   r_outstanding <= r_outstanding + CW'(1);
            2'b01:   r_outstanding <= r_outstanding - CW'(1);
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

endmodule

// File: tb/tb_hs32_fetch.sv
// Directed bench for hs32_fetch with an in-order instruction bus responder.
module tb_hs32_fetch;

   logic        clk = 1'b0;
   logic        rst_n, ibus_req, gnt, rvalid, flush, valid, ready, hold;
   logic [31:0] ibus_addr, rdata, flush_pc, data, pc;
   logic [31:0] exp_addr, exp_pc;
   logic [31:0] bq [$];
   int          checks = 0;
   int          errors = 0;
   int          grants;

   always #5 clk = ~clk;

   hs32_fetch #(.DEPTH(4), .RESET_PC(32'h0000_0100)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .ibus_req_o    (ibus_req),
      .ibus_addr_o   (ibus_addr),
      .ibus_gnt_i    (gnt),
      .ibus_rvalid_i (rvalid),
      .ibus_rdata_i  (rdata),
      .flush_i       (flush),
      .flush_pc_i    (flush_pc),
      .valid_o       (valid),
      .ready_i       (ready),
      .data_o        (data),
      .pc_o          (pc)
   );

   function automatic logic [31:0] ifn(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
   endfunction

   // Bus responder: records granted addresses, answers in order >= 1 cycle later.
   always @(posedge clk) begin
      if (!rst_n) begin
         bq.delete();
         rvalid <= 1'b0;
         rdata  <= 32'h0;
      end else begin
         if (ibus_req && gnt) bq.push_back(ibus_addr);
         if (!hold && bq.size() > 0) begin
            rvalid <= 1'b1;
            rdata  <= ifn(bq[0]);
            void'(bq.pop_front());
         end else begin
            rvalid <= 1'b0;
         end
      end
   end

   task automatic drain;
      gnt = 1'b0; ready = 1'b1; hold = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; gnt = 1'b0; ready = 1'b0; flush = 1'b0; flush_pc = 32'h0; hold = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", ibus_req); end
      checks++; if (ibus_addr !== 32'h100) begin errors++; $display("FAIL reset_addr: got %h want 00000100", ibus_addr); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
      checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data); end
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc); end
   endtask

   task automatic test_stream;
      @(negedge clk);
      rst_n = 1'b1; gnt = 1'b1; ready = 1'b1;
      exp_addr = 32'h100; exp_pc = 32'h100;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (c == 1) begin checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stream_latency_early: valid %b want 0", valid); end end
         if (c == 2) begin checks++; if (valid !== 1'b1) begin errors++; $display("FAIL stream_latency: valid %b want 1", valid); end end
         if (ibus_req && gnt) begin
            checks++; if (ibus_addr !== exp_addr) begin errors++; $display("FAIL stream_addr: got %h want %h", ibus_addr, exp_addr); end
            exp_addr += 32'd4;
         end
         if (valid && ready) begin
            checks++; if (pc !== exp_pc || data !== ifn(exp_pc)) begin errors++; $display("FAIL stream_out: got pc %h data %h want pc %h data %h", pc, data, exp_pc, ifn(exp_pc)); end
            exp_pc += 32'd4;
         end
         @(negedge clk);
      end
      checks++; if (exp_addr !== 32'h130) begin errors++; $display("FAIL stream_grants: next addr %h want 00000130", exp_addr); end
      checks++; if (exp_pc !== 32'h128) begin errors++; $display("FAIL stream_pops: next pc %h want 00000128", exp_pc); end
   endtask

   task automatic test_backpressure;
      ready = 1'b0; flush = 1'b1; flush_pc = 32'h300;
      #1;
      checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL bp_flush_req: got %b want 0", ibus_req); end
      @(negedge clk);
      flush = 1'b0; exp_addr = 32'h300; grants = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (ibus_req && gnt) begin
            checks++; if (ibus_addr !== exp_addr) begin errors++; $display("FAIL bp_addr: got %h want %h", ibus_addr, exp_addr); end
            exp_addr += 32'd4; grants++;
         end
         if (valid) begin
            checks++; if (pc !== 32'h300 || data !== ifn(32'h300)) begin errors++; $display("FAIL bp_hold: got pc %h data %h want pc 00000300 data %h", pc, data, ifn(32'h300)); end
         end
         @(negedge clk);
      end
      #1;
      checks++; if (grants !== 4) begin errors++; $display("FAIL bp_grants: got %0d want 4", grants); end
      checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL bp_req_full: got %b want 0", ibus_req); end
      @(negedge clk);
      ready = 1'b1; exp_pc = 32'h300;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (c == 0) begin checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL bp_release_req: got %b want 0", ibus_req); end end
         if (ibus_req && gnt) begin
            checks++; if (ibus_addr !== exp_addr) begin errors++; $display("FAIL bp_resume_addr: got %h want %h", ibus_addr, exp_addr); end
            exp_addr += 32'd4;
         end
         if (valid && ready) begin
            checks++; if (pc !== exp_pc || data !== ifn(exp_pc)) begin errors++; $display("FAIL bp_pop: got pc %h data %h want pc %h", pc, data, exp_pc); end
            exp_pc += 32'd4;
         end
         @(negedge clk);
      end
      checks++; if (exp_pc !== 32'h328) begin errors++; $display("FAIL bp_pop_count: next pc %h want 00000328", exp_pc); end
   endtask

   task automatic test_flush;
      drain;
      hold = 1'b1; gnt = 1'b1; flush = 1'b1; flush_pc = 32'h100;
      #1;
      checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL flush_req0: got %b want 0", ibus_req); end
      @(negedge clk); flush = 1'b0; #1;
      checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h100) begin errors++; $display("FAIL flush_a100: got req %b addr %h want 1 00000100", ibus_req, ibus_addr); end
      @(negedge clk); #1;
      checks++; if (ibus_addr !== 32'h104) begin errors++; $display("FAIL flush_a104: got %h want 00000104", ibus_addr); end
      @(negedge clk); flush = 1'b1; flush_pc = 32'h2002; #1;
      checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL flush_suppress: got %b want 0", ibus_req); end
      @(negedge clk); flush = 1'b0; hold = 1'b0; #1;
      checks++; if (ibus_addr !== 32'h2000) begin errors++; $display("FAIL flush_target: got %h want 00002000", ibus_addr); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", valid); end
      exp_pc = 32'h2000;
      for (int c = 0; c < 8; c++) begin
         if (valid && ready) begin
            checks++; if (pc !== exp_pc || data !== ifn(exp_pc)) begin errors++; $display("FAIL flush_out: got pc %h data %h want pc %h", pc, data, exp_pc); end
            exp_pc += 32'd4;
         end
         @(negedge clk); #1;
      end
      checks++; if (exp_pc !== 32'h2010) begin errors++; $display("FAIL flush_pop_count: next pc %h want 00002010", exp_pc); end
   endtask

   task automatic test_flush_rvalid;
      drain;
      gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0; flush = 1'b1; flush_pc = 32'h400; #1;
      checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL frv_suppress: got %b want 0", ibus_req); end
      @(negedge clk);
      flush = 1'b0; gnt = 1'b1; #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL frv_valid: got %b want 0", valid); end
      checks++; if (ibus_addr !== 32'h400) begin errors++; $display("FAIL frv_addr: got %h want 00000400", ibus_addr); end
      exp_pc = 32'h400;
      for (int c = 0; c < 6; c++) begin
         if (valid && ready) begin
            checks++; if (pc !== exp_pc || data !== ifn(exp_pc)) begin errors++; $display("FAIL frv_out: got pc %h data %h want pc %h", pc, data, exp_pc); end
            exp_pc += 32'd4;
         end
         @(negedge clk); #1;
      end
      checks++; if (exp_pc !== 32'h410) begin errors++; $display("FAIL frv_pop_count: next pc %h want 00000410", exp_pc); end
   endtask

   task automatic test_wrap;
      drain;
      flush = 1'b1; flush_pc = 32'hFFFF_FFF8; gnt = 1'b1;
      @(negedge clk);
      flush = 1'b0; exp_addr = 32'hFFFF_FFF8; exp_pc = 32'hFFFF_FFF8;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (ibus_req && gnt) begin
            checks++; if (ibus_addr !== exp_addr) begin errors++; $display("FAIL wrap_addr: got %h want %h", ibus_addr, exp_addr); end
            exp_addr += 32'd4;
         end
         if (valid && ready) begin
            checks++; if (pc !== exp_pc || data !== ifn(exp_pc)) begin errors++; $display("FAIL wrap_out: got pc %h data %h want pc %h", pc, data, exp_pc); end
            exp_pc += 32'd4;
         end
         @(negedge clk);
      end
      checks++; if (exp_addr !== 32'h10) begin errors++; $display("FAIL wrap_grants: next addr %h want 00000010", exp_addr); end
      checks++; if (exp_pc !== 32'h8) begin errors++; $display("FAIL wrap_pops: next pc %h want 00000008", exp_pc); end
   endtask

   task automatic test_bypass;
      drain;
      flush = 1'b1; flush_pc = 32'h500;
      @(negedge clk);
      flush = 1'b0; gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0; #1;
`ifdef HS32_FETCH_BYPASS_EN
      checks++; if (valid !== 1'b1 || pc !== 32'h500 || data !== ifn(32'h500)) begin errors++; $display("FAIL byp_same_cycle: got valid %b pc %h data %h want 1 00000500 %h", valid, pc, data, ifn(32'h500)); end
      @(negedge clk); #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL byp_fifo_empty: got valid %b want 0", valid); end
`else
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL nobyp_rsp_cycle: got valid %b want 0", valid); end
      @(negedge clk); #1;
      checks++; if (valid !== 1'b1 || pc !== 32'h500 || data !== ifn(32'h500)) begin errors++; $display("FAIL nobyp_next: got valid %b pc %h data %h want 1 00000500 %h", valid, pc, data, ifn(32'h500)); end
      @(negedge clk); #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL nobyp_drained: got valid %b want 0", valid); end
`endif
      @(negedge clk);
   endtask

   task automatic test_async_reset;
      gnt = 1'b1; ready = 1'b0;
      repeat (3) @(negedge clk);
      #2; rst_n = 1'b0; #1;
      checks++; if (ibus_req !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL areset_ctl: got req %b valid %b want 0 0", ibus_req, valid); end
      checks++; if (ibus_addr !== 32'h100 || pc !== 32'h0 || data !== 32'h0) begin errors++; $display("FAIL areset_data: got addr %h pc %h data %h want 00000100 0 0", ibus_addr, pc, data); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1; ready = 1'b1; #1;
      checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h100) begin errors++; $display("FAIL areset_restart: got req %b addr %h want 1 00000100", ibus_req, ibus_addr); end
      repeat (2) @(negedge clk); #1;
      checks++; if (valid !== 1'b1 || pc !== 32'h100 || data !== ifn(32'h100)) begin errors++; $display("FAIL areset_first: got valid %b pc %h want 1 00000100", valid, pc); end
   endtask

   initial begin
      test_reset;
      test_stream;
      test_backpressure;
      test_flush;
      test_flush_rvalid;
      test_wrap;
      test_bypass;
      test_async_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
